// File: rtl/pcie_ingress_buffer_pkg.sv
// Shared PCIe ingress-buffer definitions: FSM and bank-state encodings.
package pcie_ingress_buffer_pkg;

    localparam int unsigned NUM_BANKS = 2;
    localparam int unsigned DW        = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/pcie_ingress_buffer_ram.sv
// Simple dual-port dword RAM backing both ping-pong banks; registered read.
module pcie_ingress_buffer_ram
    import pcie_ingress_buffer_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pcie_ingress_buffer.sv
// Two-bank ping-pong ingress buffer: parser fills one bank while the other drains.
// Optional sticky o_overflow output is enabled by PCIE_INGRESS_BUF_OVERFLOW_EN.
module pcie_ingress_buffer
    import pcie_ingress_buffer_pkg::*;
#(
    parameter int unsigned BANK_AW = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start_stb,
    input  logic [31:0] i_dword_size,
    input  logic        i_buf_we,
    input  logic [31:0] i_buf_addr,
    input  logic [31:0] i_buf_dat,
    output logic [31:0] o_buf_offset,
    output logic        o_buf_rdy,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_last,
    output logic        o_busy,
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
    output logic        o_overflow,
`endif
    output logic        o_done_stb
);

    localparam int unsigned BANK_DEPTH = 2**BANK_AW;
    localparam int unsigned CW         = BANK_AW + 1;

    state_e        state_q, state_d;
    logic [31:0]   remaining_q, remaining_d;
    logic [31:0]   offset_q, offset_d;
    logic          fill_bank_q, fill_bank_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    bank_state_e   bank_st_q [NUM_BANKS];
    bank_state_e   bank_st_d [NUM_BANKS];
    logic [CW-1:0] bank_cnt_q [NUM_BANKS];
    logic [CW-1:0] bank_cnt_d [NUM_BANKS];
    logic          bank_last_q [NUM_BANKS];
    logic          bank_last_d [NUM_BANKS];
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          out_bank_q, out_bank_d;
    logic          out_end_q, out_end_d;
    logic          done_q, done_d;
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
    logic          ovf_q, ovf_d;
`endif

    logic [31:0]   rel;
    logic          in_win, buf_rdy, accept, pop, issue;
    logic [CW-1:0] fill_target;
    logic [31:0]   ram_rdata;

    assign rel    = i_buf_addr - offset_q;
    assign in_win = rel < 32'(BANK_DEPTH);
    assign fill_target = (remaining_q >= 32'(BANK_DEPTH)) ? CW'(BANK_DEPTH) : remaining_q[CW-1:0];
    assign buf_rdy = (state_q == ST_FILL) && (remaining_q != '0) && (bank_st_q[fill_bank_q] != BANK_FULL);
    assign accept  = i_buf_we && buf_rdy && in_win;
    assign pop     = valid_q && i_ready;
    // Issue a read only when the output slot is empty or being consumed, so RAM data holds while stalled.
    assign issue   = (state_q == ST_FILL) && (bank_st_q[rd_bank_q] == BANK_FULL) && (!valid_q || i_ready);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        fill_bank_d = fill_bank_q;
        fill_cnt_d  = fill_cnt_q;
        bank_st_d   = bank_st_q;
        bank_cnt_d  = bank_cnt_q;
        bank_last_d = bank_last_q;
        rd_bank_d   = rd_bank_q;
        rd_ptr_d    = rd_ptr_q;
        valid_d     = valid_q;
        last_d      = last_q;
        out_bank_d  = out_bank_q;
        out_end_d   = out_end_q;
        done_d      = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (i_start_stb) begin
                    remaining_d = i_dword_size;
                    offset_d    = '0;
                    fill_bank_d = 1'b0;
                    fill_cnt_d  = '0;
                    rd_bank_d   = 1'b0;
                    rd_ptr_d    = '0;
                    for (int unsigned b = 0; b < NUM_BANKS; b++) bank_st_d[b] = BANK_EMPTY;
                    state_d = (i_dword_size == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        if (accept) begin
            if (fill_cnt_q + CW'(1) == fill_target) begin
                bank_st_d[fill_bank_q]   = BANK_FULL;
                bank_cnt_d[fill_bank_q]  = fill_target;
                bank_last_d[fill_bank_q] = (remaining_q == 32'(fill_target));
                offset_d    = offset_q + 32'(fill_target);
                remaining_d = remaining_q - 32'(fill_target);
                fill_cnt_d  = '0;
                fill_bank_d = ~fill_bank_q;
            end else begin
                bank_st_d[fill_bank_q] = BANK_FILLING;
                fill_cnt_d = fill_cnt_q + CW'(1);
            end
        end

        if (pop) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (out_end_q) bank_st_d[out_bank_q] = BANK_EMPTY;
            if (last_q) state_d = ST_DONE;
        end

        if (issue) begin
            valid_d    = 1'b1;
            out_bank_d = rd_bank_q;
            out_end_d  = (rd_ptr_q + CW'(1) == bank_cnt_q[rd_bank_q]);
            last_d     = out_end_d && bank_last_q[rd_bank_q];
            if (out_end_d) begin
                rd_bank_d = ~rd_bank_q;
                rd_ptr_d  = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
        end

`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
        ovf_d = ovf_q | (i_buf_we & ~accept);
        if (i_start_stb) ovf_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            offset_q    <= '0;
            fill_bank_q <= 1'b0;
            fill_cnt_q  <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                bank_st_q[b]   <= BANK_EMPTY;
                bank_cnt_q[b]  <= '0;
                bank_last_q[b] <= 1'b0;
            end
            rd_bank_q   <= 1'b0;
            rd_ptr_q    <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            out_bank_q  <= 1'b0;
            out_end_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            fill_bank_q <= fill_bank_d;
            fill_cnt_q  <= fill_cnt_d;
            bank_st_q   <= bank_st_d;
            bank_cnt_q  <= bank_cnt_d;
            bank_last_q <= bank_last_d;
            rd_bank_q   <= rd_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            out_bank_q  <= out_bank_d;
            out_end_q   <= out_end_d;
            done_q      <= done_d;
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    pcie_ingress_buffer_ram #(
        .AW (CW)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i ({fill_bank_q, rel[BANK_AW-1:0]}),
        .wdata_i (i_buf_dat),
        .re_i    (issue),
        .raddr_i ({rd_bank_q, rd_ptr_q[BANK_AW-1:0]}),
        .rdata_o (ram_rdata)
    );

    assign o_buf_offset = offset_q;
    assign o_buf_rdy    = buf_rdy;
    assign o_data       = valid_q ? ram_rdata : '0;
    assign o_valid      = valid_q;
    assign o_last       = last_q;
    assign o_busy       = (state_q == ST_FILL) || (state_q == ST_DONE);
    assign o_done_stb   = done_q;
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
    assign o_overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_pcie_ingress_buffer.sv
// Scoreboard bench for pcie_ingress_buffer with BANK_AW=2 (4-dword banks).
module tb_pcie_ingress_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start_stb = 1'b0;
    logic [31:0] i_dword_size = '0;
    logic        i_buf_we = 1'b0;
    logic [31:0] i_buf_addr = '0;
    logic [31:0] i_buf_dat = '0;
    logic [31:0] o_buf_offset;
    logic        o_buf_rdy;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        o_last;
    logic        o_busy;
    logic        o_done_stb;
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
    logic        o_overflow;
`endif

    always #5 clk = ~clk;

    pcie_ingress_buffer #(
        .BANK_AW (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start_stb  (i_start_stb),
        .i_dword_size (i_dword_size),
        .i_buf_we     (i_buf_we),
        .i_buf_addr   (i_buf_addr),
        .i_buf_dat    (i_buf_dat),
        .o_buf_offset (o_buf_offset),
        .o_buf_rdy    (o_buf_rdy),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_busy       (o_busy),
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
        .o_overflow   (o_overflow),
`endif
        .o_done_stb   (o_done_stb)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned done_cnt = 0;
    int unsigned valid_cnt = 0;
    int unsigned out_cnt = 0;
    logic [32:0] sb [$];
    logic        tog_en = 1'b0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_l = 1'b0;
    logic [31:0] prev_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: handshake scoreboard plus hold-while-stalled checks.
    always @(negedge clk) begin
        logic [32:0] e;
        if (o_done_stb) done_cnt++;
        if (o_valid) valid_cnt++;
        if (!rst && prev_v && !prev_r) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_data", o_data, prev_d);
            chk("hold_last", 32'(o_last), 32'(prev_l));
        end
        if (o_valid && i_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("drain_data", o_data, e[31:0]);
                chk("drain_last", 32'(o_last), 32'(e[32]));
                out_cnt++;
            end
        end
        prev_v = o_valid;
        prev_r = i_ready;
        prev_d = o_data;
        prev_l = o_last;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (tog_en) i_ready = ~i_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] sz);
        i_dword_size = sz;
        i_start_stb  = 1'b1;
        tick();
        i_start_stb  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic push, input logic last);
        i_buf_we   = 1'b1;
        i_buf_addr = a;
        i_buf_dat  = d;
        if (push) sb.push_back({last, d});
        tick();
        i_buf_we   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned max_cyc);
        int unsigned n = 0;
        int unsigned d0 = done_cnt;
        while (done_cnt == d0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_rdy(input int unsigned max_cyc);
        int unsigned n = 0;
        while (!o_buf_rdy && n < max_cyc) begin
            tick();
            n++;
        end
        chk("rdy_return", 32'(o_buf_rdy), 32'd1);
    endtask

    initial begin
        int unsigned d0, o0, v0;

        repeat (3) tick();
        chk("rst_offset", o_buf_offset, 32'd0);
        chk("rst_rdy", 32'(o_buf_rdy), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done_stb), 32'd0);
        rst = 1'b0;
        tick();

        // Six dwords across two banks, drained concurrently.
        d0 = done_cnt; o0 = out_cnt;
        start(32'd6);
        chk("t1_busy", 32'(o_busy), 32'd1);
        chk("t1_rdy", 32'(o_buf_rdy), 32'd1);
        chk("t1_off0", o_buf_offset, 32'd0);
        for (int unsigned a = 0; a < 6; a++) begin
            wr(a, $urandom, 1'b1, a == 5);
            if (a == 3) chk("t1_off4", o_buf_offset, 32'd4);
        end
        wait_done("t1_done", 100);
        repeat (3) tick();
        chk("t1_done_once", done_cnt - d0, 32'd1);
        chk("t1_count", out_cnt - o0, 32'd6);
        chk("t1_idle", 32'(o_busy), 32'd0);

        // Zero-size transfer: done two cycles after start, no output.
        d0 = done_cnt; v0 = valid_cnt;
        start(32'd0);
        chk("t2_nodone_c1", 32'(o_done_stb), 32'd0);
        chk("t2_busy", 32'(o_busy), 32'd1);
        tick();
        chk("t2_done_c2", 32'(o_done_stb), 32'd1);
        tick();
        chk("t2_done_pulse", 32'(o_done_stb), 32'd0);
        repeat (3) tick();
        chk("t2_done_once", done_cnt - d0, 32'd1);
        chk("t2_no_valid", valid_cnt - v0, 32'd0);

        // Twelve dwords with the drain stalled until both banks are full.
        o0 = out_cnt;
        i_ready = 1'b0;
        start(32'd12);
        for (int unsigned a = 0; a < 8; a++) begin
            if (a == 7) chk("t3_rdy_before8", 32'(o_buf_rdy), 32'd1);
            wr(a, $urandom, 1'b1, 1'b0);
        end
        chk("t3_rdy_after8", 32'(o_buf_rdy), 32'd0);
        chk("t3_off8", o_buf_offset, 32'd8);
        chk("t3_valid_stalled", 32'(o_valid), 32'd1);
        tick();
        i_ready = 1'b1;
        wait_rdy(50);
        for (int unsigned a = 8; a < 12; a++) wr(a, $urandom, 1'b1, a == 11);
        wait_done("t3_done", 100);
        chk("t3_count", out_cnt - o0, 32'd12);

        // Eight dwords with i_ready toggling every cycle.
        o0 = out_cnt;
        tog_en = 1'b1;
        start(32'd8);
        for (int unsigned a = 0; a < 8; a++) wr(a, $urandom, 1'b1, a == 7);
        wait_done("t4_done", 200);
        tog_en = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("t4_count", out_cnt - o0, 32'd8);

        // Out-of-window write is dropped.
        o0 = out_cnt;
        start(32'd4);
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
        chk("t5_ovf_clear", 32'(o_overflow), 32'd0);
`endif
        wr(32'd9, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("t5_off_kept", o_buf_offset, 32'd0);
        chk("t5_rdy_kept", 32'(o_buf_rdy), 32'd1);
`ifdef PCIE_INGRESS_BUF_OVERFLOW_EN
        chk("t5_ovf_set", 32'(o_overflow), 32'd1);
`endif
        for (int unsigned a = 0; a < 4; a++) wr(a, $urandom, 1'b1, a == 3);
        wait_done("t5_done", 100);
        chk("t5_count", out_cnt - o0, 32'd4);

        // Reset mid-transfer, then a clean two-dword transfer.
        start(32'd8);
        for (int unsigned a = 0; a < 3; a++) wr(a, $urandom, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_off", o_buf_offset, 32'd0);
        chk("t6_valid", 32'(o_valid), 32'd0);
        d0 = done_cnt; o0 = out_cnt;
        repeat (5) tick();
        chk("t6_no_done", done_cnt - d0, 32'd0);
        start(32'd2);
        for (int unsigned a = 0; a < 2; a++) wr(a, $urandom, 1'b1, a == 1);
        wait_done("t6_done", 100);
        repeat (3) tick();
        chk("t6_done_once", done_cnt - d0, 32'd1);
        chk("t6_count", out_cnt - o0, 32'd2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
